// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles,
// reporting each full cycle with a one-cycle strobe and flagging an edgeless input after a timeout.
module pwm_capture #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pwm_in,
    input  logic [31:0] timeout,
    output logic [31:0] period,
    output logic [31:0] high_time,
    output logic        valid,
    output logic        stuck,
    output logic        stuck_level,
    output logic [31:0] counter_dbg
);

    typedef enum logic [1:0] {
        DISABLED,
        ARM,
        MEASURE_HIGH,
        MEASURE_LOW
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s, pwm_d, rise, fall;
    logic [31:0]            cnt, idle_cnt, high_tmp;
    logic                   active, timed_out;
    logic                   do_report, do_latch_high;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Synchroniser keeps running while disabled so edges are clean the moment capture resumes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s       = sync_q[SYNC_STAGES-1];
    assign rise        = pwm_s & ~pwm_d;
    assign fall        = ~pwm_s & pwm_d;
    assign active      = enable && (state != DISABLED);
    // An edge on the equality cycle reloads the idle counter, so it beats the timeout.
    assign timed_out   = active && (timeout != '0) && (idle_cnt == timeout) && !rise && !fall;
    assign counter_dbg = cnt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next    = state;
        do_report     = 1'b0;
        do_latch_high = 1'b0;
        if (!enable) begin
            state_next = DISABLED;
        end else if (timed_out) begin
            state_next = ARM;
        end else begin
            case (state)
                DISABLED:     state_next = ARM;
                ARM:          if (rise) state_next = MEASURE_HIGH;
                MEASURE_HIGH: if (fall) begin
                    state_next    = MEASURE_LOW;
                    do_latch_high = 1'b1;
                end
                MEASURE_LOW:  if (rise) begin
                    state_next = MEASURE_HIGH;
                    do_report  = 1'b1;
                end
                default:      state_next = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= DISABLED;
            cnt         <= '0;
            idle_cnt    <= '0;
            high_tmp    <= '0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            state <= state_next;
            valid <= 1'b0;
            if (!active) begin
                cnt      <= '0;
                idle_cnt <= '0;
            end else begin
                cnt      <= rise ? 32'd1 : sat_inc(cnt);
                idle_cnt <= (rise || fall) ? 32'd1 : sat_inc(idle_cnt);
            end
            if (do_latch_high) high_tmp <= cnt;
            if (do_report) begin
                period    <= cnt;
                high_time <= high_tmp;
                stuck     <= 1'b0;
                valid     <= 1'b1;
            end else if (timed_out) begin
                period      <= '0;
                high_time   <= '0;
                stuck       <= 1'b1;
                stuck_level <= pwm_s;
                valid       <= 1'b1;
            end
        end
    end

endmodule
